// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem address, optional BTB (macro FETCH_BTB_EN).
// Latency: imem_addr is combinational next-PC; if_pc/if_flush registered, one cycle later.
// Backpressure: pipeline_en=0 holds the PC (memory re-reads it); ex_redirect overrides a stall.
module if_fetch_stage #(
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipeline_en,
   input  logic        ex_redirect,
   input  logic [31:0] ex_redirect_pc,
   input  logic        ex_update_en,
   input  logic [31:0] ex_update_pc,
   input  logic        ex_update_taken,
   input  logic [31:0] ex_update_target,
   output logic [31:0] imem_addr,
   output logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic        if_flush
);

   logic [31:0] r_pc;
   logic        r_flush;
   logic [31:0] w_next_pc;
   logic        w_pred_taken;
   logic [31:0] w_pred_target;

`ifdef FETCH_BTB_EN
   localparam int IDX  = $clog2(BTB_ENTRIES);
   localparam int TAGW = 30 - IDX;

   logic            r_btb_vld [BTB_ENTRIES];
   logic [TAGW-1:0] r_btb_tag [BTB_ENTRIES];
   logic [31:0]     r_btb_tgt [BTB_ENTRIES];
   logic [1:0]      r_btb_ctr [BTB_ENTRIES];

   logic [IDX-1:0]  w_lk_idx;
   logic [TAGW-1:0] w_lk_tag;
   logic [IDX-1:0]  w_up_idx;
   logic [TAGW-1:0] w_up_tag;
   logic            w_up_hit;
   logic [1:0]      w_unused;

   // Word-aligned fetch: the two low address bits never select or tag an entry.
   assign w_unused      = r_pc[1:0] ^ ex_update_pc[1:0];

   assign w_lk_idx      = r_pc[IDX+1:2];
   assign w_lk_tag      = r_pc[31:IDX+2];
   assign w_up_idx      = ex_update_pc[IDX+1:2];
   assign w_up_tag      = ex_update_pc[31:IDX+2];
   assign w_up_hit      = r_btb_vld[w_up_idx] && (r_btb_tag[w_up_idx] == w_up_tag);

   // Lookup reads the current (pre-training) contents, so same-cycle training shows up next cycle.
   assign w_pred_taken  = r_btb_vld[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag)
                          && r_btb_ctr[w_lk_idx][1];
   assign w_pred_target = r_btb_tgt[w_lk_idx];

   // BTB training: saturating counter on hit, allocate weakly-taken on a taken miss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            r_btb_vld[i] <= 1'b0;
            r_btb_tag[i] <= '0;
            r_btb_tgt[i] <= '0;
            r_btb_ctr[i] <= 2'b01;
         end
      end else if (ex_update_en) begin
         if (w_up_hit) begin
            if (ex_update_taken) begin
               r_btb_tgt[w_up_idx] <= ex_update_target;
               if (r_btb_ctr[w_up_idx] != 2'b11)
                  r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] + 2'b01;
            end else if (r_btb_ctr[w_up_idx] != 2'b00) begin
               r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] - 2'b01;
            end
         end else if (ex_update_taken) begin
            r_btb_vld[w_up_idx] <= 1'b1;
            r_btb_tag[w_up_idx] <= w_up_tag;
            r_btb_tgt[w_up_idx] <= ex_update_target;
            r_btb_ctr[w_up_idx] <= 2'b10;
         end
      end
   end
`else
   localparam int unused_btb_entries = BTB_ENTRIES;
   logic w_unused;

   // Static not-taken: training inputs are accepted but have no effect.
   assign w_unused      = ^{ex_update_en, ex_update_pc, ex_update_taken, ex_update_target};
   assign w_pred_taken  = 1'b0;
   assign w_pred_target = 32'h0000_0000;
`endif

   // Next-PC priority: redirect, then stall hold, then predicted target, then sequential.
   always_comb begin
      w_next_pc = r_pc + 32'd4;
      if (ex_redirect)
         w_next_pc = ex_redirect_pc;
      else if (!pipeline_en)
         w_next_pc = r_pc;
      else if (w_pred_taken)
         w_next_pc = w_pred_target;
   end

   // PC and flush registers; flush marks the first slot after reset as a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_flush <= 1'b1;
      end else begin
         r_pc    <= w_next_pc;
         r_flush <= 1'b0;
      end
   end

   // While reset is held the memory address must not follow a redirect input.
   assign imem_addr     = rst_n ? w_next_pc : RESET_PC;
   assign if_pc         = r_pc;
   assign if_pred_taken = w_pred_taken;
   assign if_flush      = r_flush;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

`ifdef FETCH_BTB_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          NENT   = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipeline_en = 1'b0;
   logic        ex_redirect = 1'b0;
   logic [31:0] ex_redirect_pc = '0;
   logic        ex_update_en = 1'b0;
   logic [31:0] ex_update_pc = '0;
   logic        ex_update_taken = 1'b0;
   logic [31:0] ex_update_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        if_flush;

   int n_chk  = 0;
   int n_fail = 0;

   if_fetch_stage #(.BTB_ENTRIES(NENT), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .pipeline_en(pipeline_en),
      .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
      .ex_update_en(ex_update_en), .ex_update_pc(ex_update_pc),
      .ex_update_taken(ex_update_taken), .ex_update_target(ex_update_target),
      .imem_addr(imem_addr), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .if_flush(if_flush)
   );

   always #5 clk = ~clk;

   // Reference model: direct-mapped table with plain index/tag arithmetic.
   logic [31:0] m_pc;
   logic        m_flush;
   bit          m_v   [NENT];
   logic [31:0] m_tag [NENT];
   logic [31:0] m_tgt [NENT];
   int          m_ctr [NENT];

   function automatic int idx_of(input logic [31:0] p);
      return int'((p >> 2) % NENT);
   endfunction
   function automatic logic [31:0] tag_of(input logic [31:0] p);
      return p / (4 * NENT);
   endfunction

   task automatic model_reset();
      m_pc = RST_PC;
      m_flush = 1'b1;
      for (int i = 0; i < NENT; i++) begin
         m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic rd, input logic [31:0] rpc,
                        input logic ue, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg);
      pipeline_en = en; ex_redirect = rd; ex_redirect_pc = rpc;
      ex_update_en = ue; ex_update_pc = upc; ex_update_taken = ut; ex_update_target = utg;
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, advance past the next rising edge.
   task automatic cyc(input string nm, input logic en, input logic rd, input logic [31:0] rpc,
                      input logic ue, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg, input logic [31:0] e_pc, input logic e_pred,
                      input logic [31:0] e_imem, input logic e_flush);
      drive(en, rd, rpc, ue, upc, ut, utg);
      @(negedge clk);
      chk({nm, ".if_pc"}, if_pc, e_pc);
      chk({nm, ".pred"}, {31'd0, if_pred_taken}, {31'd0, e_pred});
      chk({nm, ".imem"}, imem_addr, e_imem);
      chk({nm, ".flush"}, {31'd0, if_flush}, {31'd0, e_flush});
      @(posedge clk); #1;
   endtask

   // Assert reset mid-cycle with a competing redirect; outputs must clear at once.
   task automatic do_reset();
      drive(1'b0, 1'b1, 32'hDEAD_0000, 1'b1, 32'h0000_0120, 1'b1, 32'h0000_0400);
      rst_n = 1'b0;
      #1;
      chk("rst.if_pc", if_pc, RST_PC);
      chk("rst.imem", imem_addr, RST_PC);
      chk("rst.flush", {31'd0, if_flush}, 32'd1);
      chk("rst.pred", {31'd0, if_pred_taken}, 32'd0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic        en;
      logic        rd;
      logic [31:0] rpc;
      logic [31:0] e_pc;
      logic [31:0] e_imem;
      logic        e_flush;
   } vec_t;

   vec_t vt [13];

   initial begin
      logic        r_en, r_rd, r_ue, r_ut, hit, pred;
      logic [31:0] r_rpc, r_upc, r_utg, nxt;
      int          i;

      vt[0]  = '{1'b1, 1'b0, 32'h0,         32'h100,       32'h104,       1'b1};
      vt[1]  = '{1'b1, 1'b0, 32'h0,         32'h104,       32'h108,       1'b0};
      vt[2]  = '{1'b0, 1'b0, 32'h0,         32'h108,       32'h108,       1'b0};
      vt[3]  = '{1'b0, 1'b0, 32'h0,         32'h108,       32'h108,       1'b0};
      vt[4]  = '{1'b0, 1'b0, 32'h0,         32'h108,       32'h108,       1'b0};
      vt[5]  = '{1'b1, 1'b0, 32'h0,         32'h108,       32'h10C,       1'b0};
      vt[6]  = '{1'b1, 1'b0, 32'h0,         32'h10C,       32'h110,       1'b0};
      vt[7]  = '{1'b0, 1'b1, 32'h200,       32'h110,       32'h200,       1'b0};
      vt[8]  = '{1'b1, 1'b0, 32'h0,         32'h200,       32'h204,       1'b0};
      vt[9]  = '{1'b1, 1'b0, 32'h0,         32'h204,       32'h208,       1'b0};
      vt[10] = '{1'b1, 1'b1, 32'hFFFFFFFC,  32'h208,       32'hFFFFFFFC,  1'b0};
      vt[11] = '{1'b1, 1'b0, 32'h0,         32'hFFFFFFFC,  32'h0,         1'b0};
      vt[12] = '{1'b1, 1'b0, 32'h0,         32'h0,         32'h4,         1'b0};

      model_reset();
      @(posedge clk); #1;
      do_reset();

      // Sequential fetch, stall, redirect during stall, wrap-around.
      for (int k = 0; k < 13; k++)
         cyc($sformatf("vec%0d", k), vt[k].en, vt[k].rd, vt[k].rpc, 1'b0, '0, 1'b0, '0,
             vt[k].e_pc, 1'b0, vt[k].e_imem, vt[k].e_flush);

      // Train 0x120 taken -> 0x300, then fetch through it.
      cyc("tr0", 1, 1, 32'h118, 1, 32'h120, 1, 32'h300, 32'h4,   0, 32'h118, 0);
      cyc("tr1", 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h118, 0, 32'h11C, 0);
      cyc("tr2", 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h11C, 0, 32'h120, 0);
      cyc("tr3", 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h120, BTB_ON,
          BTB_ON ? 32'h300 : 32'h124, 0);
      // Strengthen to 3 while redirecting back to 0x120.
      cyc("tr4", 1, 1, 32'h120, 1, 32'h120, 1, 32'h300,
          BTB_ON ? 32'h300 : 32'h124, 0, 32'h120, 0);
      // Two not-taken trainings under stall: lookup sees pre-update counter each cycle.
      cyc("tr5", 0, 0, 32'h0,   1, 32'h120, 0, 32'h0,   32'h120, BTB_ON, 32'h120, 0);
      cyc("tr6", 0, 0, 32'h0,   1, 32'h120, 0, 32'h0,   32'h120, BTB_ON, 32'h120, 0);
      cyc("tr7", 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h120, 0, 32'h124, 0);
      cyc("tr8", 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h124, 0, 32'h128, 0);

      // Randomized run against the reference model, with one reset in the middle.
      do_reset();
      for (i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         r_en  = ($urandom_range(0, 7) != 0);
         r_rd  = ($urandom_range(0, 9) == 0);
         r_rpc = 32'h100 + 4 * $urandom_range(0, 47);
         r_ue  = $urandom_range(0, 1) == 1;
         r_upc = 32'h100 + 4 * $urandom_range(0, 47);
         r_ut  = $urandom_range(0, 2) != 0;
         r_utg = 32'h100 + 4 * $urandom_range(0, 47);
         drive(r_en, r_rd, r_rpc, r_ue, r_upc, r_ut, r_utg);
         @(negedge clk);
         hit  = m_v[idx_of(m_pc)] && (m_tag[idx_of(m_pc)] == tag_of(m_pc));
         pred = BTB_ON && hit && (m_ctr[idx_of(m_pc)] >= 2);
         if (r_rd)       nxt = r_rpc;
         else if (!r_en) nxt = m_pc;
         else if (pred)  nxt = m_tgt[idx_of(m_pc)];
         else            nxt = m_pc + 32'd4;
         chk("rnd.if_pc", if_pc, m_pc);
         chk("rnd.pred", {31'd0, if_pred_taken}, {31'd0, pred});
         chk("rnd.imem", imem_addr, nxt);
         chk("rnd.flush", {31'd0, if_flush}, {31'd0, m_flush});
         // Advance model state as of the rising edge.
         m_pc = nxt;
         m_flush = 1'b0;
         if (BTB_ON && r_ue) begin
            if (m_v[idx_of(r_upc)] && m_tag[idx_of(r_upc)] == tag_of(r_upc)) begin
               if (r_ut) begin
                  m_tgt[idx_of(r_upc)] = r_utg;
                  m_ctr[idx_of(r_upc)] = (m_ctr[idx_of(r_upc)] < 3) ? m_ctr[idx_of(r_upc)] + 1 : 3;
               end else begin
                  m_ctr[idx_of(r_upc)] = (m_ctr[idx_of(r_upc)] > 0) ? m_ctr[idx_of(r_upc)] - 1 : 0;
               end
            end else if (r_ut) begin
               m_v[idx_of(r_upc)]   = 1;
               m_tag[idx_of(r_upc)] = tag_of(r_upc);
               m_tgt[idx_of(r_upc)] = r_utg;
               m_ctr[idx_of(r_upc)] = 2;
            end
         end
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter, drives the address of the synchronous (output-registered) instruction memory, and predicts branches with a small direct-mapped BTB of 2-bit saturating counters. It supplies `if_pc`, `if_pred_taken` and `if_flush` to IF/ID, and accepts redirect and training information from the execute stage.

## Interface
- `BTB_ENTRIES`, 16: number of BTB entries; power of two, minimum 2. `IDX = log2(BTB_ENTRIES)`.
- `RESET_PC`, 32'h00000000: PC value loaded at reset.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pipeline_en`  in  1: 1 = advance; 0 = stall and hold the PC.
- `ex_redirect`  in  1: mispredict or jump resolved in EX; overrides all other next-PC sources.
- `ex_redirect_pc`  in  32: correct next PC when `ex_redirect` = 1.
- `ex_update_en`  in  1: train the BTB this cycle.
- `ex_update_pc`  in  32: PC of the resolved branch.
- `ex_update_taken`  in  1: resolved direction.
- `ex_update_target`  in  32: resolved target.
- `imem_addr`  out  32: next-PC address presented to the instruction memory (combinational).
- `if_pc`  out  32: PC of the instruction currently at the memory output.
- `if_pred_taken`  out  1: BTB predicts taken for `if_pc` (combinational from registers).
- `if_flush`  out  1: the current fetch slot is invalid.

## Operation
- PC register `pc` drives `if_pc`.
- BTB entry fields: valid, tag `pc[31:IDX+2]`, 32-bit target, 2-bit counter. Index is `pc[IDX+1:2]`.
- Lookup on `pc`:
  - hit = valid & (tag match).
  - `if_pred_taken` = hit & `ctr[1]`.
  - `pred_target` = the entry's target.
- Next-PC selection, in priority order:
  1. `ex_redirect` → `ex_redirect_pc`.
  2. `!pipeline_en` → `pc` (hold).
  3. `if_pred_taken` → `pred_target`.
  4. Otherwise → `pc + 4`.
  - Arithmetic is modulo 2^32; wrap from 32'hFFFFFFFC to 0 is legal.
- `imem_addr` = next PC. `pc` <= next PC every cycle. During a stall the memory therefore re-reads `pc` and its output holds.
- Training (independent of `pipeline_en`, on `ex_update_en`), indexed and tagged by `ex_update_pc`:
  - Hit: counter increments (taken) or decrements (not taken), saturating at 3 and 0. Target is overwritten only when taken.
  - Miss, taken: allocate the entry. Set valid = 1, write tag and target, counter = 2'b10, replacing any prior occupant.
  - Miss, not taken: no change.
- Same-cycle lookup and training to the same index: the lookup uses pre-update contents.
- `if_flush`: register set to 1 by reset. Cleared at the first rising edge where `rst_n` = 1. While 1, the IF/ID register must treat the slot as a bubble.
- Reset values:
  - `pc` = `RESET_PC`; `if_pc` = `RESET_PC`.
  - `if_flush` = 1; `if_pred_taken` = 0.
  - All BTB valid bits = 0, counters = 2'b01.
  - `imem_addr` = `RESET_PC`.
- Reset asserted mid-operation clears all of the above immediately, regardless of `pipeline_en` or `ex_redirect`.

## Timing
- Sequential fetch: `if_pc` = A in cycle t → A+4 in cycle t+1.
- Predicted taken: a hit with `ctr[1]` = 1 in cycle t → `if_pc` = `pred_target` in t+1, with no bubble.
- Redirect: `ex_redirect` in cycle t → `if_pc` = `ex_redirect_pc` in t+1, and that instruction is valid in t+1. The EX/IF/ID flush of wrong-path slots belongs to the pipeline control, not this block.
- Redirect together with stall in the same cycle: the redirect wins; the PC loads the redirect target.
- Training in cycle t is visible to the lookup in cycle t+1.
- `if_flush` falls at the first clock edge after `rst_n` rises.

## Configuration
- Macro `FETCH_BTB_EN`.
- Defined: BTB storage, lookup and training as described above.
- Undefined:
  - No BTB storage is built.
  - `if_pred_taken` is constant 0, so the fetch predicts static not-taken.
  - Next PC is redirect, then hold, then `pc + 4`.
  - `ex_update_*` inputs are ignored.
  - All other behaviour and timing are unchanged.

## Test plan
- Reset with `RESET_PC`=32'h100, then release with `pipeline_en`=1 → `if_flush`=1 in the first cycle, then 0; `if_pc` steps 0x100, 0x104, 0x108; `if_pred_taken` stays 0.
- Drop `pipeline_en` for 3 cycles at `if_pc`=0x108 → `if_pc` and `imem_addr` hold at 0x108; sequencing resumes to 0x10C after the stall.
- Redirect to 0x200 while `pipeline_en`=0 → `if_pc`=0x200 next cycle, then 0x204.
- Train (pc 0x120, taken, target 0x300) once, then fetch through 0x120 → `if_pred_taken`=1 at 0x120; next `if_pc`=0x300.
- Starting from counter 3, train not-taken once → still predicts taken. Train not-taken a second time → predicts not taken; `if_pc` goes 0x120 → 0x124.
- With the macro undefined, repeat the training scenario → `if_pred_taken`=0 always; `if_pc` goes 0x120 → 0x124.
